// File: rtl/eros_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : eros_obi_mem_responder
// Brief    : OBI subordinate backed by a word-addressed local memory. Requests
//            are granted against a credit count of outstanding transfers,
//            travel through a fixed-latency pipeline and land in an in-order
//            response FIFO drained under rready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module eros_obi_mem_responder #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 1,
    parameter int          RSP_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    input  logic        rready_i,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int                   c_IDX_W     = $clog2(DEPTH);
    localparam int                   c_CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int                   c_PTR_W     = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [31:0]          c_SPAN      = 32'(DEPTH * 4);
    localparam logic [c_CNT_W-1:0]   c_RSP_DEPTH = c_CNT_W'(RSP_DEPTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]   c_PTR_LAST  = c_PTR_W'(RSP_DEPTH - 1);
    localparam logic [c_PTR_W-1:0]   c_PTR_ONE   = c_PTR_W'(1);

    logic [31:0]        r_mem [DEPTH];
    logic [31:0]        r_fifo_data [RSP_DEPTH];
    logic               r_fifo_err  [RSP_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_fifo_cnt;
    logic [c_CNT_W-1:0] r_outstanding;

    logic [31:0]        w_offset;
    logic               w_hit;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_accept;
    logic               w_pop;
    logic [31:0]        w_acc_data;
    logic               w_acc_err;
    logic               w_push;
    logic [31:0]        w_push_data;
    logic               w_push_err;
    logic               w_unused;

    // Address decode: the offset from the window base selects the word.
    assign w_offset = addr_i - BASE_ADDR;
    assign w_hit    = (addr_i >= BASE_ADDR) && (w_offset < c_SPAN);
    assign w_idx    = w_offset[c_IDX_W+1:2];
    assign w_unused = ^{w_offset[31:c_IDX_W+2], w_offset[1:0]};

    // Grant only while a credit is free; depends on req_i and registered count.
    assign gnt_o    = req_i && (r_outstanding < c_RSP_DEPTH) && !rst_i;
    assign w_accept = gnt_o;
    assign w_pop    = rvalid_o && rready_i;

    // Response payload formed at acceptance: reads of hits return the word,
    // writes and misses return zero, misses flag an error.
    assign w_acc_data = (w_hit && !we_i) ? r_mem[w_idx] : 32'h0;
    assign w_acc_err  = !w_hit;

    // FIFO head drives the response port; gated so reset forces zeros at once.
    assign rvalid_o = (r_fifo_cnt != '0);
    assign rdata_o  = rvalid_o ? r_fifo_data[r_rd_ptr] : 32'h0;
    assign err_o    = rvalid_o & r_fifo_err[r_rd_ptr];

    // Byte-lane write into memory in the accept cycle; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && we_i && w_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY == 1) begin : g_no_pipe
            // Single-cycle latency: accepted responses enter the FIFO directly.
            assign w_push      = w_accept;
            assign w_push_data = w_acc_data;
            assign w_push_err  = w_acc_err;
        end else begin : g_pipe
            logic [LATENCY-2:0] r_vld;
            logic [31:0]        r_data [LATENCY-1];
            logic               r_err  [LATENCY-1];

            // Valid bits of the latency pipeline; cleared by reset.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_vld <= '0;
                end else begin
                    r_vld[0] <= w_accept;
                    for (int s = 1; s < LATENCY - 1; s++) begin
                        r_vld[s] <= r_vld[s-1];
                    end
                end
            end

            // Payload shift of the latency pipeline; qualified by r_vld.
            always_ff @(posedge clk_i) begin
                r_data[0] <= w_acc_data;
                r_err[0]  <= w_acc_err;
                for (int s = 1; s < LATENCY - 1; s++) begin
                    r_data[s] <= r_data[s-1];
                    r_err[s]  <= r_err[s-1];
                end
            end

            assign w_push      = r_vld[LATENCY-2];
            assign w_push_data = r_data[LATENCY-2];
            assign w_push_err  = r_err[LATENCY-2];
        end
    endgenerate

    // Response FIFO storage; pointers and count below decide what is live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_err[r_wr_ptr]  <= w_push_err;
        end
    end

    // FIFO pointers, FIFO occupancy and outstanding-credit counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_cnt    <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_ONE;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_ONE;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - c_CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // The credit rule must keep a push from ever landing on a full FIFO.
    a_fifo_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_push && !w_pop && (r_fifo_cnt == c_RSP_DEPTH)));

endmodule
`default_nettype wire

// File: tb/tb_eros_obi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_eros_obi_mem_responder
// Brief    : Self-checking bench for eros_obi_mem_responder. Two instances
//            (LATENCY=1/RSP_DEPTH=2 and LATENCY=2/RSP_DEPTH=3) are compared
//            cycle by cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eros_obi_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [2];
    logic        we     [2];
    logic        rready [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [3:0]  be     [2];
    logic        gnt    [2];
    logic        rvalid [2];
    logic        err    [2];
    logic [31:0] rdata  [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: memory image plus a queue of expected responses per instance.
    logic [31:0] mem_m  [2][DEPTH];
    logic [31:0] q_data [2][64];
    logic        q_err  [2][64];
    int          q_cyc  [2][64];
    int          head   [2];
    int          tail   [2];

    eros_obi_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(1), .RSP_DEPTH(2)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
        .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
        .rready_i(rready[0]), .rdata_o(rdata[0]), .err_o(err[0]));

    eros_obi_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(2), .RSP_DEPTH(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
        .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
        .rready_i(rready[1]), .rdata_o(rdata[1]), .err_o(err[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic int rd_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle of the reference model, evaluated at the falling edge.
    task automatic model_step(input int i);
        int          c;
        int          idx;
        logic [31:0] off;
        logic        hit;
        logic [31:0] d;
        if (rst) begin
            chk($sformatf("rst_gnt%0d", i), {31'b0, gnt[i]}, 32'd0);
            chk($sformatf("rst_rvalid%0d", i), {31'b0, rvalid[i]}, 32'd0);
            head[i] = 0;
            tail[i] = 0;
            return;
        end
        c = tail[i] - head[i];
        chk($sformatf("gnt%0d", i), {31'b0, gnt[i]}, {31'b0, req[i] && (c < rd_of(i))});
        if (c > 0 && cyc >= q_cyc[i][head[i] % 64] + lat_of(i)) begin
            chk($sformatf("rvalid%0d", i), {31'b0, rvalid[i]}, 32'd1);
            chk($sformatf("rdata%0d", i), rdata[i], q_data[i][head[i] % 64]);
            chk($sformatf("err%0d", i), {31'b0, err[i]}, {31'b0, q_err[i][head[i] % 64]});
            if (rready[i]) head[i]++;
        end else begin
            chk($sformatf("rvalid%0d", i), {31'b0, rvalid[i]}, 32'd0);
        end
        if (req[i] && gnt[i]) begin
            off = addr[i] - BASE;
            hit = (addr[i] >= BASE) && (off < 32'(DEPTH * 4));
            idx = int'(off[9:2]);
            d   = 32'h0;
            if (hit && we[i]) begin
                for (int k = 0; k < 4; k++)
                    if (be[i][k]) mem_m[i][idx][8*k +: 8] = wdata[i][8*k +: 8];
            end else if (hit) begin
                d = mem_m[i][idx];
            end
            q_data[i][tail[i] % 64] = d;
            q_err[i][tail[i] % 64]  = !hit;
            q_cyc[i][tail[i] % 64]  = cyc;
            tail[i]++;
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Present a request and hold it until granted (bounded).
    task automatic do_xfer(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, input bit rnd_rdy, output int gcyc);
        logic g;
        bit   done;
        done = 1'b0;
        gcyc = -1;
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
        for (int n = 0; n < 40 && !done; n++) begin
            if (rnd_rdy) rready[i] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = gnt[i];
            if (g) gcyc = cyc;
            @(posedge clk);
            #1;
            if (g) done = 1'b1;
        end
        chk($sformatf("xfer_timeout%0d", i), {31'b0, done}, 32'd1);
        req[i] = 1'b0;
    endtask

    task automatic xfer(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
        int unused_cyc;
        do_xfer(i, w, a, b, d, 1'b0, unused_cyc);
    endtask

    // Let every outstanding response of instance i drain (bounded).
    task automatic wait_idle(input int i);
        bit idle;
        idle = 1'b0;
        rready[i] = 1'b1;
        for (int n = 0; n < 50 && !idle; n++) begin
            @(posedge clk);
            #1;
            if (head[i] == tail[i]) idle = 1'b1;
        end
        chk($sformatf("drain%0d", i), {31'b0, idle}, 32'd1);
    endtask

    initial begin
        int          g0;
        int          g1;
        int          gc;
        logic [31:0] a;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; be[i] = 4'h0;
            wdata[i] = 32'h0; rready[i] = 1'b1; head[i] = 0; tail[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        // Reset state, with a request pending to show grant is held off.
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b1;
            #1;
            chk("reset_gnt", {31'b0, gnt[i]}, 32'd0);
            chk("reset_rvalid", {31'b0, rvalid[i]}, 32'd0);
            chk("reset_rdata", rdata[i], 32'd0);
            chk("reset_err", {31'b0, err[i]}, 32'd0);
            req[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            // Known contents for words 0..15.
            for (int w = 0; w < 16; w++) xfer(i, 1'b1, BASE + 32'(4 * w), 4'hF, $urandom);
            // Basic write then read.
            xfer(i, 1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
            xfer(i, 1'b0, BASE + 32'h10, 4'hF, 32'h0);
            // Byte enables and read-after-write.
            xfer(i, 1'b1, BASE + 32'hC, 4'hF, 32'hFFFF_FFFF);
            xfer(i, 1'b1, BASE + 32'hC, 4'b0101, 32'h0000_0000);
            xfer(i, 1'b0, BASE + 32'hC, 4'h0, 32'h0);
            xfer(i, 1'b1, BASE + 32'hC, 4'h0, 32'h1234_5678);
            xfer(i, 1'b0, BASE + 32'hC, 4'hF, 32'h0);
            // Out-of-range read and write, then word 0 must be untouched.
            xfer(i, 1'b0, BASE + 32'(DEPTH * 4), 4'hF, 32'h0);
            xfer(i, 1'b1, BASE - 32'd4, 4'hF, 32'hA5A5_A5A5);
            xfer(i, 1'b0, BASE, 4'hF, 32'h0);
            wait_idle(i);
        end

        // Back-pressure on the RSP_DEPTH=2 instance.
        rready[0] = 1'b0;
        xfer(0, 1'b0, BASE + 32'h0, 4'hF, 32'h0);
        xfer(0, 1'b0, BASE + 32'h4, 4'hF, 32'h0);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h8;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_gnt_blocked", {31'b0, gnt[0]}, 32'd0);
        rready[0] = 1'b1;
        xfer(0, 1'b0, BASE + 32'h8, 4'hF, 32'h0);
        xfer(0, 1'b0, BASE + 32'hC, 4'hF, 32'h0);
        wait_idle(0);

        // Streaming: 16 back-to-back reads granted on 16 consecutive cycles.
        for (int i = 0; i < 2; i++) begin
            g0 = 0;
            g1 = 0;
            for (int n = 0; n < 16; n++) begin
                do_xfer(i, 1'b0, BASE + 32'(4 * n), 4'hF, 32'h0, 1'b0, gc);
                if (n == 0) g0 = gc;
                g1 = gc;
            end
            chk($sformatf("stream_span%0d", i), 32'(g1 - g0), 32'd15);
            wait_idle(i);
        end

        // Randomized traffic with random rready and idle gaps.
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < 150; n++) begin
                repeat ($urandom_range(0, 2)) begin
                    rready[i] = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 6) == 0)
                    a = ($urandom_range(0, 1) == 0) ? BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 255))
                                                    : BASE - 32'(4 * $urandom_range(1, 16));
                else
                    a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
                do_xfer(i, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 1'b1, gc);
            end
            wait_idle(i);
        end

        // Asynchronous reset with two responses outstanding.
        xfer(0, 1'b1, BASE + 32'h1C, 4'hF, 32'hCAFE_F00D);
        wait_idle(0);
        rready[0] = 1'b0;
        xfer(0, 1'b0, BASE + 32'h14, 4'hF, 32'h0);
        xfer(0, 1'b0, BASE + 32'h18, 4'hF, 32'h0);
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = BASE + 32'h1C; be[0] = 4'hF;
        #1;
        chk("pre_rst_rvalid", {31'b0, rvalid[0]}, 32'd1);
        chk("pre_rst_gnt", {31'b0, gnt[0]}, 32'd0);
        rst = 1'b1;
        #1;
        chk("async_rst_rvalid", {31'b0, rvalid[0]}, 32'd0);
        chk("async_rst_gnt", {31'b0, gnt[0]}, 32'd0);
        chk("async_rst_rdata", rdata[0], 32'd0);
        chk("async_rst_err", {31'b0, err[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rready[0] = 1'b1;
        xfer(0, 1'b0, BASE + 32'h1C, 4'hF, 32'h0);
        xfer(0, 1'b0, BASE + 32'h10, 4'hF, 32'h0);
        wait_idle(0);
        wait_idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
